// File: rtl/dlsc_pcie_s6_inbound_read_cpl_gate.sv
// ----------------------------------------------------------------------------
// dlsc_pcie_s6_inbound_read_cpl_gate
//
// Purpose:
//   Holds one read-completion slice at a time between the RCB splitter and
//   the completion TLP generator. A slice is released only when enough
//   read-data DWs are buffered, a completion header credit is free and
//   enough completion data credits (16 bytes each) are free. On release the
//   buffered words and both credit types are deducted; credit returns and
//   read-data pushes replenish them.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       slice handshake from the splitter
//   in_addr/len/bytes/last  slice payload (len 0 means 1024 DWs)
//   out_valid/out_ready     slice handshake to the TLP generator
//   out_addr/len/bytes/last registered slice payload
//   data_push               one DW written into the read buffer
//   ret_valid/ret_len       credit return for one completed TLP
//   cplh_avail/cpld_avail   current header / data credits
//   words_avail             current buffered DWs
//   err                     sticky counter overflow flag
// ----------------------------------------------------------------------------
module dlsc_pcie_s6_inbound_read_cpl_gate #(
   parameter int CPLH_INIT = 8,
   parameter int CPLD_INIT = 64,
   parameter int BUF_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        in_ready,
   input  logic        in_valid,
   input  logic [6:0]  in_addr,
   input  logic [9:0]  in_len,
   input  logic [11:0] in_bytes,
   input  logic        in_last,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [6:0]  out_addr,
   output logic [9:0]  out_len,
   output logic [11:0] out_bytes,
   output logic        out_last,
   input  logic        data_push,
   input  logic        ret_valid,
   input  logic [9:0]  ret_len,
   output logic [7:0]  cplh_avail,
   output logic [11:0] cpld_avail,
   output logic [10:0] words_avail,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   // Counter limits widened to the 13-bit working width used for net updates,
   // which holds every limit plus a full 256-credit / 1024-word step.
   localparam logic [12:0] CPLH_MAX  = 13'(CPLH_INIT);
   localparam logic [12:0] CPLD_MAX  = 13'(CPLD_INIT);
   localparam logic [12:0] WORDS_MAX = 13'(BUF_WORDS);

   state_t      state_q, state_d;
   logic [6:0]  addr_q, addr_d;
   logic [9:0]  len_q, len_d;
   logic [11:0] bytes_q, bytes_d;
   logic        last_q, last_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  cplh_q, cplh_d;
   logic [11:0] cpld_q, cpld_d;
   logic [10:0] words_q, words_d;
   logic        err_q, err_d;

   // Decoded lengths (0 -> 1024) and their data-credit cost ceil(L/4).
   logic [10:0] len_dec, len_p3, rlen_dec, rlen_p3;
   logic [8:0]  dcred, rcred;
   logic        grant;
   logic [12:0] cplh_sum, cpld_sum, words_sum;

   assign len_dec  = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
   assign len_p3   = len_dec + 11'd3;
   assign dcred    = len_p3[10:2];
   assign rlen_dec = (ret_len == 10'd0) ? 11'd1024 : {1'b0, ret_len};
   assign rlen_p3  = rlen_dec + 11'd3;
   assign rcred    = rlen_p3[10:2];

   // Grant looks only at registered (pre-update) counter values.
   assign grant = (state_q == ST_WAIT) &&
                  ({4'd0, cplh_q} >= 12'd1) &&
                  (cpld_q >= {3'd0, dcred}) &&
                  ({1'b0, words_q} >= {1'b0, len_dec});

   // Slice FSM: accept in IDLE, hold in WAIT until granted, present in SEND.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      bytes_d     = bytes_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               addr_d  = in_addr;
               len_d   = in_len;
               bytes_d = in_bytes;
               last_d  = in_last;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (grant) begin
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Net per-cycle counter update. Underflow is impossible because a grant
   // requires every counter to cover its own deduction; an increment that
   // would pass the limit saturates and raises the sticky error.
   always_comb begin
      cplh_sum  = 13'(cplh_q) + 13'(ret_valid) - (grant ? 13'd1 : 13'd0);
      cpld_sum  = 13'(cpld_q) + (ret_valid ? 13'(rcred) : 13'd0)
                  - (grant ? 13'(dcred) : 13'd0);
      words_sum = 13'(words_q) + 13'(data_push) - (grant ? 13'(len_dec) : 13'd0);
      err_d     = err_q;
      cplh_d    = cplh_sum[7:0];
      cpld_d    = cpld_sum[11:0];
      words_d   = words_sum[10:0];
      if (cplh_sum > CPLH_MAX) begin
         cplh_d = CPLH_MAX[7:0];
         err_d  = 1'b1;
      end
      if (cpld_sum > CPLD_MAX) begin
         cpld_d = CPLD_MAX[11:0];
         err_d  = 1'b1;
      end
      if (words_sum > WORDS_MAX) begin
         words_d = WORDS_MAX[10:0];
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         bytes_q     <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         cplh_q      <= CPLH_MAX[7:0];
         cpld_q      <= CPLD_MAX[11:0];
         words_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         bytes_q     <= bytes_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         cplh_q      <= cplh_d;
         cpld_q      <= cpld_d;
         words_q     <= words_d;
         err_q       <= err_d;
      end
   end

   // in_ready is masked by reset so it reads 0 while rst_n is asserted.
   assign in_ready    = rst_n && (state_q == ST_IDLE);
   assign out_valid   = out_valid_q;
   assign out_addr    = addr_q;
   assign out_len     = len_q;
   assign out_bytes   = bytes_q;
   assign out_last    = last_q;
   assign cplh_avail  = cplh_q;
   assign cpld_avail  = cpld_q;
   assign words_avail = words_q;
   assign err         = err_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_read_cpl_gate.sv
// ----------------------------------------------------------------------------
// tb_dlsc_pcie_s6_inbound_read_cpl_gate
//
// Directed bench with two gate instances: index 0 uses the default credits
// (8 header / 64 data), index 1 has 256 data credits so a 1024-DW slice can
// be issued. Inputs change and outputs are sampled 1 ns after each rising
// edge.
// ----------------------------------------------------------------------------
module tb_dlsc_pcie_s6_inbound_read_cpl_gate;

   localparam int NDUT = 2;
   localparam int CPLD_P [NDUT] = '{64, 256};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_ready    [NDUT];
   logic        in_valid    [NDUT];
   logic [6:0]  in_addr     [NDUT];
   logic [9:0]  in_len      [NDUT];
   logic [11:0] in_bytes    [NDUT];
   logic        in_last     [NDUT];
   logic        out_ready   [NDUT];
   logic        out_valid   [NDUT];
   logic [6:0]  out_addr    [NDUT];
   logic [9:0]  out_len     [NDUT];
   logic [11:0] out_bytes   [NDUT];
   logic        out_last    [NDUT];
   logic        data_push   [NDUT];
   logic        ret_valid   [NDUT];
   logic [9:0]  ret_len     [NDUT];
   logic [7:0]  cplh_avail  [NDUT];
   logic [11:0] cpld_avail  [NDUT];
   logic [10:0] words_avail [NDUT];
   logic        err         [NDUT];

   genvar gi;
   generate
      for (gi = 0; gi < NDUT; gi++) begin : g_dut
         dlsc_pcie_s6_inbound_read_cpl_gate #(
            .CPLH_INIT (8),
            .CPLD_INIT (CPLD_P[gi]),
            .BUF_WORDS (1024)
         ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_ready    (in_ready[gi]),
            .in_valid    (in_valid[gi]),
            .in_addr     (in_addr[gi]),
            .in_len      (in_len[gi]),
            .in_bytes    (in_bytes[gi]),
            .in_last     (in_last[gi]),
            .out_ready   (out_ready[gi]),
            .out_valid   (out_valid[gi]),
            .out_addr    (out_addr[gi]),
            .out_len     (out_len[gi]),
            .out_bytes   (out_bytes[gi]),
            .out_last    (out_last[gi]),
            .data_push   (data_push[gi]),
            .ret_valid   (ret_valid[gi]),
            .ret_len     (ret_len[gi]),
            .cplh_avail  (cplh_avail[gi]),
            .cpld_avail  (cpld_avail[gi]),
            .words_avail (words_avail[gi]),
            .err         (err[gi])
         );
      end
   endgenerate

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks_total++;
      if (obs == exp) begin
         checks_passed++;
         $display("check %-24s got %0d expected %0d ok", tag, obs, exp);
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input int n);
      data_push[k] = 1'b1;
      repeat (n) step();
      data_push[k] = 1'b0;
   endtask

   // Presents a slice for exactly one edge; the gate must be in IDLE.
   task automatic offer(input int k, input logic [6:0] a, input logic [9:0] l,
                        input logic [11:0] b, input logic la);
      in_valid[k] = 1'b1;
      in_addr[k]  = a;
      in_len[k]   = l;
      in_bytes[k] = b;
      in_last[k]  = la;
      step();
      in_valid[k] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         in_valid[k]  = 1'b0;
         in_addr[k]   = '0;
         in_len[k]    = '0;
         in_bytes[k]  = '0;
         in_last[k]   = 1'b0;
         out_ready[k] = 1'b1;
         data_push[k] = 1'b0;
         ret_valid[k] = 1'b0;
         ret_len[k]   = '0;
      end
      step();
      step();

      // Reset state while rst_n is still low
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("rst_in_ready[%0d]", k), int'(in_ready[k]), 0);
         check($sformatf("rst_out_valid[%0d]", k), int'(out_valid[k]), 0);
         check($sformatf("rst_cplh[%0d]", k), int'(cplh_avail[k]), 8);
         check($sformatf("rst_cpld[%0d]", k), int'(cpld_avail[k]), CPLD_P[k]);
         check($sformatf("rst_words[%0d]", k), int'(words_avail[k]), 0);
         check($sformatf("rst_err[%0d]", k), int'(err[k]), 0);
      end
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", int'(in_ready[0]), 1);

      // Basic issue: 4 DWs, len 4 -> D=1
      push(0, 4);
      check("basic_words_in", int'(words_avail[0]), 4);
      offer(0, 7'h10, 10'd4, 12'd16, 1'b1);
      check("basic_wait_valid", int'(out_valid[0]), 0);
      check("basic_wait_ready", int'(in_ready[0]), 0);
      step();
      check("basic_out_valid", int'(out_valid[0]), 1);
      check("basic_out_addr", int'(out_addr[0]), 'h10);
      check("basic_out_len", int'(out_len[0]), 4);
      check("basic_out_bytes", int'(out_bytes[0]), 16);
      check("basic_out_last", int'(out_last[0]), 1);
      check("basic_cplh", int'(cplh_avail[0]), 7);
      check("basic_cpld", int'(cpld_avail[0]), 63);
      check("basic_words", int'(words_avail[0]), 0);
      step();
      check("basic_done_valid", int'(out_valid[0]), 0);
      check("basic_done_ready", int'(in_ready[0]), 1);

      // Data starvation: len 16 (D=4) with only 15 DWs
      push(0, 15);
      offer(0, 7'h00, 10'd16, 12'd64, 1'b0);
      repeat (3) step();
      check("starve_held_valid", int'(out_valid[0]), 0);
      check("starve_held_words", int'(words_avail[0]), 15);
      check("starve_held_cpld", int'(cpld_avail[0]), 63);
      push(0, 1);
      check("starve_push_edge_valid", int'(out_valid[0]), 0);
      check("starve_push_edge_words", int'(words_avail[0]), 16);
      step();
      check("starve_grant_valid", int'(out_valid[0]), 1);
      check("starve_grant_words", int'(words_avail[0]), 0);
      check("starve_grant_cpld", int'(cpld_avail[0]), 59);
      check("starve_grant_cplh", int'(cplh_avail[0]), 6);
      check("starve_out_len", int'(out_len[0]), 16);
      step();

      // Simultaneous grant (len 8, D=2) with return (len 4, 1 credit) and push
      push(0, 8);
      offer(0, 7'h01, 10'd8, 12'd32, 1'b1);
      ret_valid[0] = 1'b1;
      ret_len[0]   = 10'd4;
      data_push[0] = 1'b1;
      step();
      ret_valid[0] = 1'b0;
      data_push[0] = 1'b0;
      check("simul_valid", int'(out_valid[0]), 1);
      check("simul_cplh", int'(cplh_avail[0]), 6);
      check("simul_cpld", int'(cpld_avail[0]), 58);
      check("simul_words", int'(words_avail[0]), 1);
      check("simul_err", int'(err[0]), 0);
      step();

      // Reset while presenting a slice with out_ready low
      out_ready[0] = 1'b0;
      offer(0, 7'h22, 10'd1, 12'd4, 1'b1);
      step();
      step();
      check("send_hold_valid", int'(out_valid[0]), 1);
      check("send_hold_addr", int'(out_addr[0]), 'h22);
      do_reset();
      out_ready[0] = 1'b1;
      check("mid_rst_valid", int'(out_valid[0]), 0);
      check("mid_rst_ready", int'(in_ready[0]), 1);
      check("mid_rst_cplh", int'(cplh_avail[0]), 8);
      check("mid_rst_cpld", int'(cpld_avail[0]), 64);
      check("mid_rst_words", int'(words_avail[0]), 0);
      check("mid_rst_addr", int'(out_addr[0]), 0);

      // Word counter overflow: BUF_WORDS+1 pushes
      push(0, 1025);
      check("ovf_words", int'(words_avail[0]), 1024);
      check("ovf_err", int'(err[0]), 1);
      repeat (2) step();
      check("ovf_err_sticky", int'(err[0]), 1);
      do_reset();
      check("ovf_err_cleared", int'(err[0]), 0);

      // Credit return while already at the initial credit levels
      ret_valid[0] = 1'b1;
      ret_len[0]   = 10'd4;
      step();
      ret_valid[0] = 1'b0;
      check("ret_ovf_cplh", int'(cplh_avail[0]), 8);
      check("ret_ovf_cpld", int'(cpld_avail[0]), 64);
      check("ret_ovf_err", int'(err[0]), 1);

      // Max length on instance 1: len 0 = 1024 DWs, D=256
      push(1, 1024);
      check("max_words_in", int'(words_avail[1]), 1024);
      offer(1, 7'h00, 10'd0, 12'd0, 1'b1);
      step();
      check("max_valid", int'(out_valid[1]), 1);
      check("max_out_len", int'(out_len[1]), 0);
      check("max_words", int'(words_avail[1]), 0);
      check("max_cpld", int'(cpld_avail[1]), 0);
      check("max_cplh", int'(cplh_avail[1]), 7);
      step();

      // Credit starvation on instance 1: cpld 0, slice len 32 needs D=8
      push(1, 32);
      offer(1, 7'h40, 10'd32, 12'd128, 1'b1);
      repeat (3) step();
      check("cred_held_valid", int'(out_valid[1]), 0);
      check("cred_held_ready", int'(in_ready[1]), 0);
      check("cred_held_cpld", int'(cpld_avail[1]), 0);
      ret_valid[1] = 1'b1;
      ret_len[1]   = 10'd32;
      step();
      ret_valid[1] = 1'b0;
      check("cred_ret_cpld", int'(cpld_avail[1]), 8);
      check("cred_ret_cplh", int'(cplh_avail[1]), 8);
      check("cred_ret_valid", int'(out_valid[1]), 0);
      step();
      check("cred_grant_valid", int'(out_valid[1]), 1);
      check("cred_grant_cpld", int'(cpld_avail[1]), 0);
      check("cred_grant_cplh", int'(cplh_avail[1]), 7);
      check("cred_grant_words", int'(words_avail[1]), 0);
      check("cred_grant_err", int'(err[1]), 0);
      step();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/dlsc_pcie_s6_inbound_read_cpl_gate.md
Name: dlsc_pcie_s6_inbound_read_cpl_gate

Overview:
- Sits between the inbound read-completion splitter (RCB stage) and the completion TLP generator.
- Holds each completion slice until three things are true: enough read-data DWs are buffered, a completion header credit is free, and enough completion data credits are free.
- On issue it deducts the buffered words and both credit types. Credit returns and data arrivals replenish the counters.
- One slice is in flight at a time, with fixed registered latency.

Parameters:
- CPLH_INIT, 8, header credits available after reset (1..255).
- CPLD_INIT, 64, data credits available after reset, 16 bytes each (1..2047).
- BUF_WORDS, 1024, read-data buffer depth in DWs; sets the word counter range 0..BUF_WORDS.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_ready  out  1  slice accepted
- in_valid  in  1  slice valid
- in_addr  in  7  lower address of the completion
- in_len  in  10  slice length in DWs; 0 means 1024
- in_bytes  in  12  byte count remaining
- in_last  in  1  last slice of the request
- out_ready  in  1  TLP generator accepts
- out_valid  out  1  slice released
- out_addr  out  7  registered copy of in_addr
- out_len  out  10  registered copy of in_len
- out_bytes  out  12  registered copy of in_bytes
- out_last  out  1  registered copy of in_last
- data_push  in  1  one DW written into the read buffer this cycle
- ret_valid  in  1  credit return for one completed TLP
- ret_len  in  10  DW length of the returned TLP; 0 means 1024
- cplh_avail  out  8  current header credits
- cpld_avail  out  12  current data credits
- words_avail  out  11  current buffered DWs
- err  out  1  sticky; a counter overflowed or underflowed

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; in_ready=0 during reset, 1 in the first cycle after.
  - out_valid=0; out_* payload regs=0; err=0.
  - cplh_avail=CPLH_INIT, cpld_avail=CPLD_INIT, words_avail=0.
  - A held slice is dropped. A reset mid-operation restores the same values.
- Derived quantities:
  - L = (len==0) ? 1024 : len, 11 bits.
  - Data credits needed D = ceil(L/4) = (L+3)>>2, range 1..256.
- FSM IDLE:
  - in_ready=1.
  - On in_valid, latch in_addr/len/bytes/last into the payload regs and go to WAIT.
- FSM WAIT:
  - in_ready=0.
  - Grant when cplh_avail>=1 AND cpld_avail>=D AND words_avail>=L.
  - On grant: deduct 1 header credit, D data credits and L words; set out_valid=1; go to SEND.
  - Otherwise stay in WAIT indefinitely, with no timeout.
- FSM SEND:
  - out_valid=1, payload stable.
  - On out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0 in SEND (no overlap). The next slice is accepted in IDLE.
- Latency: a slice accepted at edge N is granted at the earliest at edge N+1; out_valid is high starting the cycle after edge N+1.
- Throughput: at most one slice per 3 cycles.
- Counter updates are net per cycle:
  - words_avail += data_push − (grant ? L : 0).
  - cplh_avail += ret_valid − grant.
  - cpld_avail += (ret_valid ? ceil(RL/4) : 0) − (grant ? D : 0), where RL is ret_len decoded like L.
  - A return or push in the same cycle as a grant must be counted; grant evaluation uses pre-update values.
- Overflow checks:
  - words_avail would exceed BUF_WORDS, cplh_avail would exceed CPLH_INIT, or cpld_avail would exceed CPLD_INIT: saturate at the limit and set err.
  - A data_push when words_avail==BUF_WORDS sets err and is not counted.
- Underflow: cannot occur by construction.
- Arithmetic width rule: all compares are unsigned, on counters zero-extended to 12 bits.

Test Plan:
- Basic issue:
  - Stimulus: push 4 DWs, then slice len=4, addr=7'h10, bytes=16, last=1, out_ready=1.
  - Response: out_valid one cycle after the grant edge with out_addr=10h, out_bytes=16, out_last=1; cplh 8→7, cpld 64→63, words 4→0.
- Data starvation:
  - Stimulus: slice len=16 with 15 DWs pushed.
  - Response: stays in WAIT with out_valid=0. After the 16th push, grant on the following edge; words_avail=0.
- Credit starvation:
  - Stimulus: CPLD_INIT=4, slice len=32 (D=8), 32 DWs buffered.
  - Response: held.
  - Then: ret_valid with ret_len=16 brings cpld to 8 → grant; cpld=0.
- Max length:
  - Stimulus: len=0 with BUF_WORDS=1024 and 1024 DWs pushed, CPLD_INIT=256.
  - Response: grant; deduct 1024 words and 256 data credits; out_len=0.
- Simultaneous events:
  - Stimulus: grant (len=8, D=2) in the same cycle as ret_valid ret_len=4 and data_push.
  - Response: net cpld −1, cplh unchanged, words −7.
- Reset and error:
  - Stimulus: rst_n=0 while in SEND with out_ready=0.
  - Response: next cycle out_valid=0, in_ready=1, counters at INIT/0.
  - Then: push BUF_WORDS+1 DWs → words=BUF_WORDS, err=1, sticky until reset.
